// File: rtl/fetch_pkg.sv
// Shared widths and the queued fetch entry for the dual-issue fetch front end.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_W     = 32;
  localparam int FETCH_WIDTH = 2;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ring_buffer.sv
// Two-write/two-read circular buffer; reads show head and head+1 from registered state.
// Writer must never overrun; flush empties it in one cycle and beats a same-cycle push.
module fetch_ring_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push_vld,
  input  fetch_entry_t                 wr_dat0,
  input  fetch_entry_t                 wr_dat1,
  input  logic [1:0]                   pop_cnt,
  output fetch_entry_t                 rd_dat0,
  output fetch_entry_t                 rd_dat1,
  output logic                         rd_vld0,
  output logic                         rd_vld1,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count_q, count_d;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_cnt);
      tail_d  = push_vld ? tail_q + PTR_W'(FETCH_WIDTH) : tail_q;
      count_d = count_q + (push_vld ? CNT_W'(FETCH_WIDTH) : CNT_W'(0)) - CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_vld) begin
      mem_q[tail_q]  <= wr_dat0;
      mem_q[tail_p1] <= wr_dat1;
    end
  end

  assign rd_dat0 = mem_q[head_q];
  assign rd_dat1 = mem_q[head_p1];
  assign rd_vld0 = (count_q != '0);
  assign rd_vld1 = (count_q >= CNT_W'(2));
  assign count   = count_q;

  a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
endmodule

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch: paired imem requests into a ring, two oldest shown per cycle; visible 2 cycles after request.
// Requests only issue when the ring has room for everything in flight; stall freezes outputs, redirect flushes.
module dual_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] PC_RESET = fetch_pkg::PC_RESET
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data0,
  input  logic [31:0]     imem_rsp_data1,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     instruction1,
  output logic [31:0]     instruction2,
  output logic            ins1_valid,
  output logic            ins2_valid,
  output logic [XLEN-1:0] pc1,
  output logic [XLEN-1:0] pc2
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = CNT_W + 2;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             drop_rsp_q, drop_rsp_d;
  logic             push_vld, rd_vld0, rd_vld1;
  logic [1:0]       pop_cnt;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] need;
  fetch_entry_t     wr_dat0, wr_dat1, rd_dat0, rd_dat1;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Room check counts an in-flight pair as already occupying two slots.
  assign need           = SUM_W'(count) + (inflight_q ? SUM_W'(4) : SUM_W'(2));
  assign imem_req_valid = !rst && !redirect_valid && (need <= SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign push_vld = imem_rsp_valid && inflight_q && !drop_rsp_q;
  assign wr_dat0  = '{instr: imem_rsp_data0, pc: req_pc_q};
  assign wr_dat1  = '{instr: imem_rsp_data1, pc: req_pc_q + XLEN'(4)};
  assign pop_cnt  = stall ? 2'd0 : (rd_vld1 ? 2'd2 : (rd_vld0 ? 2'd1 : 2'd0));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    drop_rsp_d = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_rsp_d = inflight_q;
    end else if (imem_req_valid) begin
      fetch_pc_d = fetch_pc_q + XLEN'(8);
      req_pc_d   = fetch_pc_q;
    end
    if (imem_req_valid)      inflight_d = 1'b1;
    else if (imem_rsp_valid) inflight_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= PC_RESET;
      req_pc_q   <= PC_RESET;
      inflight_q <= 1'b0;
      drop_rsp_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_rsp_q <= drop_rsp_d;
    end
  end

  fetch_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push_vld (push_vld),
    .wr_dat0  (wr_dat0),
    .wr_dat1  (wr_dat1),
    .pop_cnt  (pop_cnt),
    .rd_dat0  (rd_dat0),
    .rd_dat1  (rd_dat1),
    .rd_vld0  (rd_vld0),
    .rd_vld1  (rd_vld1),
    .count    (count)
  );

  assign ins1_valid   = !rst && rd_vld0;
  assign ins2_valid   = !rst && rd_vld1;
  assign instruction1 = ins1_valid ? rd_dat0.instr : '0;
  assign pc1          = ins1_valid ? rd_dat0.pc    : '0;
  assign instruction2 = ins2_valid ? rd_dat1.instr : '0;
  assign pc2          = ins2_valid ? rd_dat1.pc    : '0;

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> inflight_q);
endmodule
